// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-RAM arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    IREAD,
    DREAD,
    DWRITE
  } arb_req_t;

  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

  // Within one CPU a write beats a data read, which beats an instruction fetch.
  function automatic arb_req_t pick_type(input logic dr, input logic dw);
    if (dw)      return DWRITE;
    else if (dr) return DREAD;
    else         return IREAD;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bundle served by mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned CPUS = 2
);
  import mem_arbiter_pkg::*;

  logic [CPUS-1:0]    iREN;
  logic [CPUS*32-1:0] iaddr;
  logic [CPUS-1:0]    dREN;
  logic [CPUS-1:0]    dWEN;
  logic [CPUS*32-1:0] daddr;
  logic [CPUS*32-1:0] dstore;
  logic [CPUS-1:0]    iwait;
  logic [CPUS-1:0]    dwait;
  logic [CPUS*32-1:0] iload;
  logic [CPUS*32-1:0] dload;
  logic               ramREN;
  logic               ramWEN;
  word_t              ramaddr;
  word_t              ramstore;
  word_t              ramload;
  ramstate_t          ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_rr_select.sv
// Round-robin picker: first requesting CPU at or after i_ptr, wrapping.
module rr_select #(
  parameter int unsigned CPUS = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [CPUS-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [2*CPUS-1:0] w_rot;

  // Rotating the doubled vector puts the scan start at bit 0.
  assign w_rot = {i_req, i_req} >> i_ptr;

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid = 1'b1;
        o_idx   = IW'((32'(i_ptr) + k) % CPUS);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises per-CPU I/D cache requests onto one RAM port.
// Optional REQ-state timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus,
  output logic          arb_err
);

  localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t      r_state;
  arb_req_t        r_type;
  logic [IW-1:0]   r_cpu;
  logic [IW-1:0]   r_rr_ptr;
  logic [CPUS-1:0] r_iwait;
  logic [CPUS-1:0] r_dwait;
  word_t           r_iload [CPUS];
  word_t           r_dload [CPUS];
  logic            r_ren;
  logic            r_wen;
  word_t           r_ramaddr;
  word_t           r_ramstore;
  logic            r_err;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0]      r_tmo;
`endif

  word_t           w_iaddr  [CPUS];
  word_t           w_daddr  [CPUS];
  word_t           w_dstore [CPUS];
  logic [CPUS-1:0] w_req;
  logic [IW-1:0]   w_idx;
  logic            w_valid;
  arb_req_t        w_type;
  logic            w_done;
  logic            w_fail;
  word_t           w_rdata;

  for (genvar g = 0; g < CPUS; g++) begin : g_lane
    assign w_iaddr[g]             = bus.iaddr[g*32 +: 32];
    assign w_daddr[g]             = bus.daddr[g*32 +: 32];
    assign w_dstore[g]            = bus.dstore[g*32 +: 32];
    assign bus.iload[g*32 +: 32]  = r_iload[g];
    assign bus.dload[g*32 +: 32]  = r_dload[g];
  end

  assign w_req        = bus.iREN | bus.dREN | bus.dWEN;
  assign w_type       = pick_type(bus.dREN[w_idx], bus.dWEN[w_idx]);
  assign bus.iwait    = r_iwait;
  assign bus.dwait    = r_dwait;
  assign bus.ramREN   = r_ren;
  assign bus.ramWEN   = r_wen;
  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;
  assign arb_err      = r_err;

  rr_select #(
    .CPUS (CPUS),
    .IW   (IW)
  ) u_rr_select (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Completion decode for the REQ state; errors and timeouts both return a fixed word.
  always_comb begin
    w_done  = 1'b0;
    w_fail  = 1'b0;
    w_rdata = bus.ramload;
    case (bus.ramstate)
      ACCESS: w_done = 1'b1;
      ERROR: begin
        w_done  = 1'b1;
        w_fail  = 1'b1;
        w_rdata = '0;
      end
      default: ;
    endcase
`ifdef MEM_ARB_TIMEOUT_EN
    if (!w_done && r_tmo == 8'(TIMEOUT - 1)) begin
      w_done  = 1'b1;
      w_fail  = 1'b1;
      w_rdata = ARB_ERR_WORD;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_type     <= IREAD;
      r_cpu      <= '0;
      r_rr_ptr   <= '0;
      r_iwait    <= '1;
      r_dwait    <= '1;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_err      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_tmo      <= '0;
`endif
      for (int unsigned c = 0; c < CPUS; c++) begin
        r_iload[c] <= '0;
        r_dload[c] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_cpu      <= w_idx;
            r_type     <= w_type;
            r_ramaddr  <= (w_type == IREAD) ? w_iaddr[w_idx] : w_daddr[w_idx];
            r_ramstore <= w_dstore[w_idx];
            r_ren      <= (w_type != DWRITE);
            r_wen      <= (w_type == DWRITE);
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo      <= '0;
`endif
            r_state    <= REQ;
          end
        end
        REQ: begin
`ifdef MEM_ARB_TIMEOUT_EN
          r_tmo <= r_tmo + 8'd1;
`endif
          if (w_done) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_state <= RESP;
            if (w_fail) r_err <= 1'b1;
            if (r_type == IREAD) begin
              r_iload[r_cpu] <= w_rdata;
              r_iwait[r_cpu] <= 1'b0;
            end else begin
              r_dwait[r_cpu] <= 1'b0;
              if (r_type == DREAD) r_dload[r_cpu] <= w_rdata;
            end
          end
        end
        RESP: begin
          r_iwait  <= '1;
          r_dwait  <= '1;
          r_rr_ptr <= (r_cpu == IW'(CPUS - 1)) ? '0 : r_cpu + 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (two CPUs).
// Define MEM_ARB_TIMEOUT_EN to also exercise the REQ timeout with TIMEOUT=4.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned NC = 2;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif
  localparam word_t K = 32'h5A5A_0000;

  logic  CLK;
  logic  RST;
  logic  arb_err;
  logic  auto_load;
  word_t load_val;
  int unsigned n_checks;
  int unsigned n_fail;

  mem_arbiter_if #(.CPUS(NC)) bus ();

  mem_arbiter #(
    .CPUS    (NC),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus.slave),
    .arb_err (arb_err)
  );

  // RAM model: either a fixed word or the address scrambled by K.
  assign bus.ramload = auto_load ? (bus.ramaddr ^ K) : load_val;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    auto_load    = 1'b0;
    load_val     = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  function automatic word_t slot(input logic [NC*32-1:0] v, input int unsigned c);
    return v[c*32 +: 32];
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    do_reset();

    // Reset state
    check_eq("rst_iwait",   32'(bus.iwait), 32'h3);
    check_eq("rst_dwait",   32'(bus.dwait), 32'h3);
    check_eq("rst_iload0",  slot(bus.iload, 0), 32'h0);
    check_eq("rst_dload1",  slot(bus.dload, 1), 32'h0);
    check_eq("rst_ramREN",  32'(bus.ramREN), 32'h0);
    check_eq("rst_ramWEN",  32'(bus.ramWEN), 32'h0);
    check_eq("rst_ramaddr", bus.ramaddr, 32'h0);
    check_eq("rst_ramstore", bus.ramstore, 32'h0);
    check_eq("rst_err",     32'(arb_err), 32'h0);

    // CPU0 instruction read, ACCESS on first REQ cycle
    load_val         = 32'h12345678;
    bus.iaddr[31:0]  = 32'h40;
    bus.iREN         = 2'b01;
    tick();
    check_eq("t1_ramREN",  32'(bus.ramREN), 32'h1);
    check_eq("t1_ramWEN",  32'(bus.ramWEN), 32'h0);
    check_eq("t1_ramaddr", bus.ramaddr, 32'h40);
    check_eq("t1_iwait_c1", 32'(bus.iwait), 32'h3);
    bus.ramstate = ACCESS;
    tick();
    check_eq("t1_iwait_c2", 32'(bus.iwait), 32'h2);
    check_eq("t1_iload0",   slot(bus.iload, 0), 32'h12345678);
    check_eq("t1_ramREN_c2", 32'(bus.ramREN), 32'h0);
    bus.iREN     = '0;
    bus.ramstate = FREE;
    tick();
    check_eq("t1_iwait_c3", 32'(bus.iwait), 32'h3);
    check_eq("t1_iload_hold", slot(bus.iload, 0), 32'h12345678);

    // CPU0 write, RAM BUSY for three cycles then ACCESS
    bus.daddr[31:0]  = 32'h80;
    bus.dstore[31:0] = 32'hDEADBEEF;
    bus.dWEN         = 2'b01;
    bus.ramstate     = BUSY;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("t2_ramWEN_%0d", i),   32'(bus.ramWEN), 32'h1);
      check_eq($sformatf("t2_ramREN_%0d", i),   32'(bus.ramREN), 32'h0);
      check_eq($sformatf("t2_ramaddr_%0d", i),  bus.ramaddr, 32'h80);
      check_eq($sformatf("t2_ramstore_%0d", i), bus.ramstore, 32'hDEADBEEF);
      check_eq($sformatf("t2_dwait_%0d", i),    32'(bus.dwait), 32'h3);
      bus.ramstate = (i == 3) ? ACCESS : BUSY;
    end
    tick();
    check_eq("t2_dwait_pulse", 32'(bus.dwait), 32'h2);
    check_eq("t2_iwait",       32'(bus.iwait), 32'h3);
    check_eq("t2_ramWEN_off",  32'(bus.ramWEN), 32'h0);
    bus.dWEN     = '0;
    bus.ramstate = FREE;
    tick();
    check_eq("t2_dwait_after", 32'(bus.dwait), 32'h3);

    // Both CPUs read continuously: grants alternate starting at CPU0
    do_reset();
    auto_load    = 1'b1;
    bus.ramstate = ACCESS;
    bus.daddr    = {32'h200, 32'h100};
    bus.dREN     = 2'b11;
    for (int t = 0; t < 4; t++) begin
      int unsigned cpu;
      word_t       addr;
      cpu  = t % 2;
      addr = (cpu == 0) ? 32'h100 : 32'h200;
      tick();
      check_eq($sformatf("t3_ramaddr_%0d", t), bus.ramaddr, addr);
      check_eq($sformatf("t3_ramREN_%0d", t),  32'(bus.ramREN), 32'h1);
      check_eq($sformatf("t3_dwait_c1_%0d", t), 32'(bus.dwait), 32'h3);
      tick();
      check_eq($sformatf("t3_dwait_%0d", t), 32'(bus.dwait), (cpu == 0) ? 32'h2 : 32'h1);
      check_eq($sformatf("t3_dload_%0d", t), slot(bus.dload, cpu), addr ^ K);
      tick();
    end
    bus.dREN = '0;
    tick();
    check_eq("t3_idle_ramREN", 32'(bus.ramREN), 32'h0);

    // CPU0 iREN and dREN together: data first, then instruction
    do_reset();
    auto_load        = 1'b1;
    bus.ramstate     = ACCESS;
    bus.iaddr[31:0]  = 32'h300;
    bus.daddr[31:0]  = 32'h400;
    bus.iREN         = 2'b01;
    bus.dREN         = 2'b01;
    tick();
    check_eq("t4_first_addr", bus.ramaddr, 32'h400);
    tick();
    check_eq("t4_dwait", 32'(bus.dwait), 32'h2);
    check_eq("t4_iwait_hold", 32'(bus.iwait), 32'h3);
    check_eq("t4_dload", slot(bus.dload, 0), 32'h400 ^ K);
    bus.dREN = '0;
    tick();
    tick();
    check_eq("t4_second_addr", bus.ramaddr, 32'h300);
    check_eq("t4_second_ren",  32'(bus.ramREN), 32'h1);
    tick();
    check_eq("t4_iwait", 32'(bus.iwait), 32'h2);
    check_eq("t4_iload", slot(bus.iload, 0), 32'h300 ^ K);
    check_eq("t4_dwait_idle", 32'(bus.dwait), 32'h3);
    bus.iREN = '0;
    tick();

    // Good read on CPU1, then an ERROR read on CPU1
    bus.daddr[63:32] = 32'h500;
    bus.dREN         = 2'b10;
    tick();
    tick();
    check_eq("t5_good_dload", slot(bus.dload, 1), 32'h500 ^ K);
    check_eq("t5_good_err",   32'(arb_err), 32'h0);
    bus.dREN = '0;
    tick();
    bus.dREN     = 2'b10;
    bus.ramstate = ERROR;
    tick();
    check_eq("t5_err_ren", 32'(bus.ramREN), 32'h1);
    tick();
    check_eq("t5_err_dwait", 32'(bus.dwait), 32'h1);
    check_eq("t5_err_dload", slot(bus.dload, 1), 32'h0);
    check_eq("t5_err_flag",  32'(arb_err), 32'h1);
    bus.dREN     = '0;
    bus.ramstate = FREE;
    tick();
    tick();
    tick();
    check_eq("t5_err_sticky", 32'(arb_err), 32'h1);

    // Reset asserted mid-REQ
    bus.daddr[31:0] = 32'h700;
    bus.dREN        = 2'b01;
    bus.ramstate    = BUSY;
    tick();
    check_eq("t6_ren_before", 32'(bus.ramREN), 32'h1);
    check_eq("t6_addr_before", bus.ramaddr, 32'h700);
    #2;
    RST = 1'b1;
    #1;
    check_eq("t6_async_ren",  32'(bus.ramREN), 32'h0);
    check_eq("t6_async_addr", bus.ramaddr, 32'h0);
    check_eq("t6_async_err",  32'(arb_err), 32'h0);
    bus.dREN     = '0;
    bus.ramstate = ACCESS;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t6_no_dwait_%0d", i), 32'(bus.dwait), 32'h3);
      check_eq($sformatf("t6_no_iwait_%0d", i), 32'(bus.iwait), 32'h3);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // RAM stuck BUSY: forced completion after TIMEOUT REQ cycles
    do_reset();
    bus.daddr[31:0] = 32'h600;
    bus.dREN        = 2'b01;
    bus.ramstate    = BUSY;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("t7_ren_%0d", i),   32'(bus.ramREN), 32'h1);
      check_eq($sformatf("t7_dwait_%0d", i), 32'(bus.dwait), 32'h3);
    end
    tick();
    check_eq("t7_dwait", 32'(bus.dwait), 32'h2);
    check_eq("t7_dload", slot(bus.dload, 0), 32'hBAD1BAD1);
    check_eq("t7_err",   32'(arb_err), 32'h1);
    bus.dREN = '0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the cache-control protocol. Services instruction and data requests from up to CPUS cache pairs; each pair presents iREN/iaddr and dREN/dWEN/daddr/dstore and waits on iwait/dwait.
- Serialises all requests onto the single RAM port (ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate).
- Returns each completed transaction to its requester as a one-cycle wait-low pulse.
- Sits between the per-core caches blocks and system RAM.

Parameters:
- CPUS, 2, number of cache pairs served (1..4).
- TIMEOUT, 255, max REQ-state cycles before forced completion (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  CPUS  per-CPU instruction read request.
- iaddr  in  CPUS*32  per-CPU instruction address.
- dREN  in  CPUS  per-CPU data read request.
- dWEN  in  CPUS  per-CPU data write request.
- daddr  in  CPUS*32  per-CPU data address.
- dstore  in  CPUS*32  per-CPU write data.
- iwait  out  CPUS  low exactly on the instruction response cycle.
- dwait  out  CPUS  low exactly on the data response cycle.
- iload  out  CPUS*32  instruction response data.
- dload  out  CPUS*32  data response data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- arb_err  out  1  sticky error flag.

Behaviour:
- Reset values: iwait/dwait all 1; iload/dload 0; ramREN/ramWEN 0; ramaddr/ramstore 0; arb_err 0; FSM IDLE; rr_ptr 0.
- FSM IDLE:
  - Scan CPUs round-robin starting at rr_ptr; pick the first CPU with any request.
  - Within that CPU, priority is dWEN > dREN > iREN.
  - Latch cpu index, type, address and store data, then go to REQ.
  - No requests: stay in IDLE.
- FSM REQ:
  - Drive ramREN (reads) or ramWEN (writes), with ramaddr/ramstore from the latched registers only. Live inputs are never passed combinationally to RAM.
  - ramstate ACCESS: latch ramload (reads), go to RESP.
  - ramstate ERROR: latch 0, set arb_err, go to RESP.
  - ramstate FREE or BUSY: hold.
- FSM RESP:
  - RAM strobes low.
  - Drive the latched data on the selected CPU's iload/dload and pull its iwait/dwait low for exactly this cycle.
  - rr_ptr = (cpu+1) mod CPUS; go to IDLE.
- Latency: request visible in cycle 0; RAM strobe in cycle 1; earliest wait-low in cycle 2 (ACCESS in cycle 1). Back-to-back transactions to the same port are 3 cycles apart minimum.
- iload/dload hold their last response value outside RESP. Other CPUs' waits stay 1.
- Request dropped mid-REQ: the transaction still completes and the response pulse is still issued.
- dWEN and dREN both high on one CPU: treated as a write only.
- iREN and dREN/dWEN on the same CPU: data is served first; instruction is served on a later pass. Fairness: a CPU requesting continuously is served at least once every CPUS transactions.
- RST asserted mid-transaction: immediate return to reset values; the in-flight RAM access is abandoned and no response is issued.
- arb_err is cleared only by RST.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter (cleared on entering REQ) increments each REQ cycle.
  - On reaching TIMEOUT without ACCESS/ERROR: complete as ERROR, with response data 32'hBAD1BAD1 and arb_err set.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- cpu_types_pkg (shared): word_t; ramstate_t (FREE/BUSY/ACCESS/ERROR); new arb_state_t (IDLE/REQ/RESP); new arb_req_t (IREAD/DREAD/DWRITE); constant ARB_ERR_WORD = 32'hBAD1BAD1.
- Sub-module rr_select: combinational, takes the per-CPU request vector and rr_ptr, returns the grant index and valid. Instantiated once.

Test Plan:
- CPU0 iREN, addr 0x40, RAM returns ACCESS with 0x12345678 on first REQ cycle -> ramREN=1/ramaddr=0x40 in cycle 1; iwait[0]=0 with iload[0]=0x12345678 in cycle 2 only.
- CPU0 dWEN, addr 0x80, data 0xDEADBEEF, RAM BUSY 3 cycles then ACCESS -> ramWEN/ramstore held 4 cycles; dwait[0] low one cycle; iwait unaffected.
- CPU0 and CPU1 both assert dREN continuously, rr_ptr=0 -> grants alternate CPU0, CPU1, CPU0…; neither waits more than one other transaction.
- CPU0 iREN+dREN same cycle -> data served first (dwait[0] pulse), then instruction (iwait[0] pulse).
- ramstate=ERROR on a read -> dload=0, dwait pulse, arb_err=1 sticky; RST mid-REQ -> ramREN drops asynchronously, no wait pulse, arb_err=0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=4, RAM stuck BUSY -> response after 4 REQ cycles with data 0xBAD1BAD1 and arb_err=1.
